lsb_ascii_decoder: RTL and testbench

LSB_ASCII_DECODER -- requirements
Module: lsb_ascii_decoder

---
 rtl/steg_pkg.sv | 25 ++
 rtl/lsb_shift_packer.sv | 60 ++++++
 rtl/lsb_ascii_decoder.sv | 191 +++++++++++++++++++
 tb/tb_lsb_ascii_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/steg_pkg.sv
// rtl/steg_pkg.sv - shared constants, FSM state type and helpers for the LSB ASCII decoder
package steg_pkg;

    localparam int SRAM_ADDR_WIDTH = 7;
    localparam int SRAM_DATA_WIDTH = 4;
    localparam int DATA_WIDTH      = 8;
    localparam int ROW_STRIDE      = 40;
    localparam int ROWS            = 3;
    localparam int BITS_PER_WORD   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SHIFT,
        S_EMIT,
        S_DONE
    } state_e;

    // Printable ASCII range, space through tilde
    function automatic logic is_printable(input logic [DATA_WIDTH-1:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/lsb_shift_packer.sv
// rtl/lsb_shift_packer.sv - holds one 3-bit SRAM word and packs its bits MSB-first into a character
module lsb_shift_packer
    import steg_pkg::*;
#(
    parameter int CHAR_W = DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic [BITS_PER_WORD-1:0] word_i,
    input  logic                     shift_i,
    output logic [CHAR_W-1:0]        char_o,
    output logic                     char_full_o,
    output logic                     last_bit_o,
    output logic                     word_empty_o
);

    logic [BITS_PER_WORD-1:0] word_q;
    logic [1:0]               bit_idx_q;
    logic [CHAR_W-1:0]        shreg_q;
    logic [3:0]               cnt_q;
    logic                     cur_bit;

    // Select the next unconsumed bit of the held word, bit 0 first
    always_comb begin
        cur_bit = 1'b0;
        case (bit_idx_q)
            2'd0:    cur_bit = word_q[0];
            2'd1:    cur_bit = word_q[1];
            2'd2:    cur_bit = word_q[2];
            default: cur_bit = 1'b0;
        endcase
    end

    // char_o/char_full_o describe the character as it would be after shifting cur_bit now,
    // so the controller can decide on the same cycle the final bit goes in
    assign char_o       = {shreg_q[CHAR_W-2:0], cur_bit};
    assign char_full_o  = (cnt_q == 4'(CHAR_W - 1));
    assign last_bit_o   = (bit_idx_q == 2'(BITS_PER_WORD - 1));
    assign word_empty_o = (bit_idx_q == 2'(BITS_PER_WORD));

    // Word load, bit-serial shift and character bit count; the count wraps on a full character
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            word_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
        end else if (load_i) begin
            word_q    <= word_i;
            bit_idx_q <= '0;
        end else if (shift_i) begin
            shreg_q   <= char_o;
            cnt_q     <= char_full_o ? 4'd0 : cnt_q + 4'd1;
            bit_idx_q <= bit_idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/lsb_ascii_decoder.sv
// rtl/lsb_ascii_decoder.sv - scans LSB-SRAM rows and decodes embedded ASCII; ASCII_PRINTABLE_FILTER_EN drops non-printable chars
module lsb_ascii_decoder #(
    parameter int SRAM_ADDR_WIDTH = steg_pkg::SRAM_ADDR_WIDTH,
    parameter int SRAM_DATA_WIDTH = steg_pkg::SRAM_DATA_WIDTH,
    parameter int DATA_WIDTH      = steg_pkg::DATA_WIDTH,
    parameter int ROW_STRIDE      = steg_pkg::ROW_STRIDE,
    parameter int ROWS            = steg_pkg::ROWS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [6:0]                 num_blocks,
    output logic                       sram_en,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_q,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_char,
    input  logic                       out_ready,
    output logic                       done
);
    import steg_pkg::state_e;
    import steg_pkg::S_IDLE;
    import steg_pkg::S_REQ;
    import steg_pkg::S_WAIT;
    import steg_pkg::S_SHIFT;
    import steg_pkg::S_EMIT;
    import steg_pkg::S_DONE;
    import steg_pkg::BITS_PER_WORD;
`ifdef ASCII_PRINTABLE_FILTER_EN
    import steg_pkg::is_printable;
`endif

    localparam int AW    = SRAM_ADDR_WIDTH;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_e               state_q;
    logic [6:0]           nblk_q;
    logic [6:0]           blk_q;
    logic [ROW_W-1:0]     row_q;
    logic [AW-1:0]        row_base_q;
    logic                 sram_en_q;
    logic [AW-1:0]        sram_addr_q;
    logic                 out_valid_q;
    logic [DATA_WIDTH-1:0] out_char_q;
    logic                 done_q;

    logic [DATA_WIDTH-1:0] pk_char;
    logic                  pk_full;
    logic                  pk_last_bit;
    logic                  pk_empty;
    logic                  unused_sram_hi;

    logic [6:0]    nb_clamped;
    logic          last_blk;
    logic          last_addr;
    logic [AW-1:0] next_addr;
    logic          keep;
    logic          char_nul;
    logic          bits_left;
    logic          do_cont;
    state_e        cont_state;

    // Only the low three bits of each SRAM word carry payload
    assign unused_sram_hi = ^sram_q[SRAM_DATA_WIDTH-1:BITS_PER_WORD];

    lsb_shift_packer #(
        .CHAR_W (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (state_q == S_DONE),
        .load_i       (state_q == S_WAIT),
        .word_i       (sram_q[BITS_PER_WORD-1:0]),
        .shift_i      (state_q == S_SHIFT),
        .char_o       (pk_char),
        .char_full_o  (pk_full),
        .last_bit_o   (pk_last_bit),
        .word_empty_o (pk_empty)
    );

    // Scan bookkeeping and the "carry on" decision shared by SHIFT and EMIT
    always_comb begin
        nb_clamped = (num_blocks > 7'(ROW_STRIDE)) ? 7'(ROW_STRIDE) : num_blocks;
        last_blk   = (blk_q == nblk_q - 7'd1);
        last_addr  = last_blk && (row_q == ROW_W'(ROWS - 1));
        next_addr  = last_blk ? row_base_q + AW'(ROW_STRIDE) : sram_addr_q + AW'(1);
`ifdef ASCII_PRINTABLE_FILTER_EN
        keep = is_printable(pk_char);
`else
        keep = 1'b1;
`endif
        char_nul  = (pk_char == '0);
        // In SHIFT the current bit is being consumed now; in EMIT it was consumed already
        bits_left = (state_q == S_SHIFT) ? !pk_last_bit : !pk_empty;
        do_cont   = ((state_q == S_SHIFT) && (!pk_full || (!char_nul && !keep))) ||
                    ((state_q == S_EMIT) && out_ready);
        if (bits_left) begin
            cont_state = S_SHIFT;
        end else if (last_addr) begin
            cont_state = S_DONE;
        end else begin
            cont_state = S_REQ;
        end
    end

    // Decoder FSM with registered read strobe, character output and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            nblk_q      <= '0;
            blk_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            sram_en_q   <= 1'b0;
            sram_addr_q <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            sram_en_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nblk_q      <= nb_clamped;
                        blk_q       <= '0;
                        row_q       <= '0;
                        row_base_q  <= '0;
                        sram_addr_q <= '0;
                        if (nb_clamped == 7'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_REQ;
                            sram_en_q <= 1'b1;
                        end
                    end
                end
                S_REQ:  state_q <= S_WAIT;
                S_WAIT: state_q <= S_SHIFT;
                S_SHIFT: begin
                    if (pk_full && char_nul) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (pk_full && keep) begin
                        out_char_q  <= pk_char;
                        out_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    nblk_q      <= '0;
                    blk_q       <= '0;
                    row_q       <= '0;
                    row_base_q  <= '0;
                    sram_addr_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
            if (do_cont) begin
                state_q <= cont_state;
                if (cont_state == S_REQ) begin
                    sram_en_q   <= 1'b1;
                    sram_addr_q <= next_addr;
                    if (last_blk) begin
                        blk_q      <= '0;
                        row_q      <= row_q + ROW_W'(1);
                        row_base_q <= next_addr;
                    end else begin
                        blk_q <= blk_q + 7'd1;
                    end
                end else if (cont_state == S_DONE) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign sram_en   = sram_en_q;
    assign sram_addr = sram_addr_q;
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lsb_ascii_decoder.sv
// tb/tb_lsb_ascii_decoder.sv - directed self-checking bench for lsb_ascii_decoder
module tb_lsb_ascii_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] num_blocks;
    logic       sram_en;
    logic [6:0] sram_addr;
    logic [3:0] sram_q = 4'h0;
    logic       out_valid;
    logic [7:0] out_char;
    logic       out_ready;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mem [0:127];
    int         addr_log[$];
    logic [7:0] char_log[$];
    int         done_cnt = 0;

    lsb_ascii_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_blocks (num_blocks),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_q     (sram_q),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .out_ready  (out_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    // SRAM model: read data one cycle after the enable
    always @(posedge clk) begin
        if (sram_en) sram_q <= mem[sram_addr];
    end

    // Transaction recorder
    always @(posedge clk) begin
        if (sram_en) addr_log.push_back(int'(sram_addr));
        if (out_valid && out_ready) char_log.push_back(out_char);
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // "Hi" then NUL, packed three bits per word; bit 3 set to show it is ignored
    task automatic load_hi();
        logic [2:0] w [0:7];
        w = '{3'd2, 3'd2, 3'd0, 3'd3, 3'd1, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 128; i++) mem[i] = 4'b1000;
        for (int i = 0; i < 8; i++) mem[i] = {1'b1, w[i]};
    endtask

    task automatic load_ones();
        for (int i = 0; i < 128; i++) mem[i] = 4'b1111;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        char_log.delete();
    endtask

    task automatic pulse_start(input logic [6:0] nb);
        @(negedge clk);
        num_blocks = nb;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    int d0;
    int en0;
    int exp_ff;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        num_blocks = 7'd0;
        out_ready  = 1'b1;
        load_hi();
        repeat (3) @(negedge clk);
        check("rst_sram_en",   {31'd0, sram_en},   32'd0);
        check("rst_sram_addr", {25'd0, sram_addr}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_char",  {24'd0, out_char},  32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        rst = 1'b0;

        // "Hi" decode with a ready consumer
        clear_logs();
        d0 = done_cnt;
        pulse_start(7'd16);
        wait_done("hi_done");
        repeat (5) @(negedge clk);
        check("hi_nchars", char_log.size(), 32'd2);
        if (char_log.size() == 2) begin
            check("hi_char0", {24'd0, char_log[0]}, 32'h48);
            check("hi_char1", {24'd0, char_log[1]}, 32'h69);
        end
        check("hi_nreads", addr_log.size(), 32'd8);
        for (int i = 0; i < addr_log.size() && i < 8; i++)
            check("hi_addr", addr_log[i], i);
        check("hi_done_cnt", done_cnt - d0, 32'd1);

        // Back-pressure on the first character
        clear_logs();
        out_ready = 1'b0;
        pulse_start(7'd16);
        begin
            int n;
            n = 0;
            while (out_valid !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        en0 = addr_log.size();
        check("bp_reads_at_emit", en0, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_char",  {24'd0, out_char},  32'h48);
        end
        check("bp_no_extra_reads", addr_log.size(), en0);
        out_ready = 1'b1;
        wait_done("bp_done");
        check("bp_nchars", char_log.size(), 32'd2);
        if (char_log.size() == 2) begin
            check("bp_char0", {24'd0, char_log[0]}, 32'h48);
            check("bp_char1", {24'd0, char_log[1]}, 32'h69);
        end
        check("bp_nreads", addr_log.size(), 32'd8);

        // num_blocks == 0 finishes immediately
        clear_logs();
        pulse_start(7'd0);
        check("zero_done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("zero_done_low", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("zero_reads", addr_log.size(), 32'd0);
        check("zero_chars", char_log.size(), 32'd0);

        // All-ones payload across three rows, two blocks each
        load_ones();
`ifdef ASCII_PRINTABLE_FILTER_EN
        exp_ff = 0;
`else
        exp_ff = 2;
`endif
        clear_logs();
        d0 = done_cnt;
        pulse_start(7'd2);
        wait_done("ones_done");
        check("ones_nreads", addr_log.size(), 32'd6);
        if (addr_log.size() == 6) begin
            check("ones_addr0", addr_log[0], 32'd0);
            check("ones_addr1", addr_log[1], 32'd1);
            check("ones_addr2", addr_log[2], 32'd40);
            check("ones_addr3", addr_log[3], 32'd41);
            check("ones_addr4", addr_log[4], 32'd80);
            check("ones_addr5", addr_log[5], 32'd81);
        end
        check("ones_nchars", char_log.size(), exp_ff);
        for (int i = 0; i < char_log.size(); i++)
            check("ones_char", {24'd0, char_log[i]}, 32'hFF);
        check("ones_done_cnt", done_cnt - d0, 32'd1);

        // Oversized num_blocks clamps to the row stride: 120 reads, 360 bits, 45 chars
`ifdef ASCII_PRINTABLE_FILTER_EN
        exp_ff = 0;
`else
        exp_ff = 45;
`endif
        clear_logs();
        pulse_start(7'd127);
        wait_done("clamp_done");
        check("clamp_nreads", addr_log.size(), 32'd120);
        if (addr_log.size() == 120) begin
            check("clamp_addr39",  addr_log[39],  32'd39);
            check("clamp_addr40",  addr_log[40],  32'd40);
            check("clamp_addr80",  addr_log[80],  32'd80);
            check("clamp_addr119", addr_log[119], 32'd119);
        end
        check("clamp_nchars", char_log.size(), exp_ff);

        // Reset during EMIT, then a clean restart
        load_hi();
        clear_logs();
        d0 = done_cnt;
        out_ready = 1'b0;
        pulse_start(7'd16);
        begin
            int n;
            n = 0;
            while (out_valid !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("rstmid_in_emit", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_en",    {31'd0, sram_en},   32'd0);
        check("rstmid_done",  {31'd0, done},      32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_no_chars", char_log.size(), 32'd0);
        check("rstmid_no_done",  done_cnt - d0,   32'd0);
        clear_logs();
        pulse_start(7'd16);
        wait_done("restart_done");
        check("restart_first_addr", (addr_log.size() > 0) ? addr_log[0] : -1, 32'd0);
        check("restart_nchars", char_log.size(), 32'd2);
        if (char_log.size() == 2) begin
            check("restart_char0", {24'd0, char_log[0]}, 32'h48);
            check("restart_char1", {24'd0, char_log[1]}, 32'h69);
        end

        // start pulses during a decode are ignored
        clear_logs();
        pulse_start(7'd16);
        repeat (3) @(negedge clk);
        start = 1'b1; num_blocks = 7'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1; num_blocks = 7'd0;
        @(negedge clk);
        start = 1'b0; num_blocks = 7'd16;
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done");
        check("ign_nreads", addr_log.size(), 32'd8);
        for (int i = 0; i < addr_log.size() && i < 8; i++)
            check("ign_addr", addr_log[i], i);
        check("ign_nchars", char_log.size(), 32'd2);
        if (char_log.size() == 2) begin
            check("ign_char0", {24'd0, char_log[0]}, 32'h48);
            check("ign_char1", {24'd0, char_log[1]}, 32'h69);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
